request_scheduler: RTL and testbench
====================================

REQUEST_SCHEDULER -- requirements
Module: request_scheduler

Interface
REQ-001 Parameter NFLOORS, default 8, number of floors; floor index width FW = 3.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 up  input  NFLOORS  hall-up request vector, level, bit i = floor i, sampled every clock.
REQ-005 down  input  NFLOORS  hall-down request vector, same format as up.
REQ-006 elevator_btn  input  NFLOORS  in-car floor-button vector, same format as up.
REQ-007 cur_floor  input  FW  floor the car is currently at or passing.
REQ-008 arrived  input  1  one-cycle pulse: car stopped at cur_floor, doors opening.
REQ-009 dir  output  2  scheduler state: 00 IDLE, 01 UP, 10 DOWN.
REQ-010 target_floor  output  FW  next floor to stop at; valid only when target_valid=1.
REQ-011 target_valid  output  1  a target exists.
REQ-012 pend_up, pend_down, pend_car  output  NFLOORS each  latched pending requests, for LED display.
REQ-013 serve  output  1  one-cycle pulse: at least one pending bit cleared this cycle.

Function
REQ-014 Pending bits shall be set-sticky: pend_x[i] is set in the cycle after input x[i]=1 and stays set until served.
REQ-015 If a set and a clear hit the same bit in the same cycle, the set shall win and the bit shall remain 1.
REQ-016 Definitions: above = any pend bit at floor > cur_floor; below = any pend bit at floor < cur_floor; here = any pend bit at cur_floor.
REQ-017 IDLE: if here, clear all three bits at cur_floor and pulse serve; else if above go UP; else if below go DOWN; else stay IDLE.
REQ-018 If here and (above or below) in IDLE, serving shall take priority; the transition occurs the next cycle.
REQ-019 UP: target_floor = lowest floor > cur_floor with pend_up or pend_car set; if none, highest floor > cur_floor with pend_down set.
REQ-020 DOWN: mirror of REQ-019: highest floor < cur_floor with pend_down|pend_car, else lowest floor < cur_floor with pend_up.
REQ-021 On arrived in UP: clear pend_car[cur] and pend_up[cur]; also clear pend_down[cur] if no bit remains above; pulse serve if any bit cleared.
REQ-022 On arrived in DOWN: mirror of REQ-021 with up/down swapped.
REQ-023 After arrived, UP shall become DOWN if nothing remains above and below is true, IDLE if nothing remains above or below, else stay UP; DOWN mirrors this.
REQ-024 arrived while IDLE shall be treated as REQ-017 (serve here) and shall not change dir.
REQ-025 cur_floor >= NFLOORS shall be ignored: no clear, no transition, and target_valid forced to 0.
REQ-026 target_valid shall be 1 exactly when dir != IDLE and a candidate exists under REQ-019/020.
REQ-027 All outputs shall be registered; a request input change shall be visible on target_floor two cycles later (latch, then select).
REQ-028 No wrap-around: floor 0 has no below and floor NFLOORS-1 has no above.

Reset
REQ-029 While rst_n=0: dir=IDLE, target_floor=0, target_valid=0, serve=0, all pend_* = 0.
REQ-030 Reset asserted mid-operation shall discard all pending requests; no serve pulse is produced on exit from reset.

Structure
REQ-031 Shared package elevator_pkg shall hold NFLOORS, FW, and the dir encoding (DIR_IDLE, DIR_UP, DIR_DOWN).
REQ-032 Target search shall be one sub-module, floor_search: a combinational priority finder (lowest/highest set bit above/below a floor) instantiated for each search in REQ-019/020.
REQ-033 The pending registers and the 3-state FSM shall reside in request_scheduler.

Verification
REQ-034 Reset, then a 1-cycle pulse on up[5] with cur_floor=2: pend_up=0x20; dir=UP; target_floor=5 and target_valid=1 two cycles later.
REQ-035 dir=UP, cur_floor=3, pend_car[4], pend_up[6], pend_down[7]: target=4; arrived at 4 -> target=6; arrived at 6 -> target=7; arrived at 7 clears pend_down[7] -> IDLE.
REQ-036 IDLE, cur_floor=0, elevator_btn[0]=1 for one cycle: serve pulses once, pend_car=0, dir stays IDLE.
REQ-037 arrived at floor 4 in UP while up[4] is held high the same cycle: pend_up[4] remains 1 (REQ-015).
REQ-038 dir=DOWN with requests at floors 1 and 6, rst_n pulsed low mid-run: all outputs return to reset values; no serve pulse after release.
REQ-039 Floor boundaries: car at 7 with only pend_car[0] -> DOWN, target 0; car at 0 with only pend_up[7] -> UP, target 7; no wrap-around.

Source files
------------

// File: rtl/elevator_pkg.sv
// ============================================================================
// Module      : elevator_pkg
// Description : Shared constants and the scheduler direction encoding used by
//               request_scheduler and floor_search.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package elevator_pkg;

    // Number of floors served and the width of a floor index.
    localparam int NFLOORS = 8;
    localparam int FW      = 3;

    // Scheduler direction / state encoding, also driven on the dir port.
    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_t;

endpackage

`default_nettype wire

// File: rtl/floor_search.sv
// ============================================================================
// Module      : floor_search
// Description : Combinational priority finder. Looks at the set bits of vec
//               strictly above (ABOVE=1) or strictly below (ABOVE=0) floor,
//               and returns the lowest (LOWEST=1) or highest (LOWEST=0) one.
// Ports       : vec   - candidate bit vector, bit i = floor i
//               floor - reference floor (excluded from the search)
//               found - at least one candidate exists
//               idx   - index of the selected candidate (0 when none)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module floor_search
    import elevator_pkg::*;
#(
    parameter int N      = NFLOORS,
    parameter bit ABOVE  = 1'b1,
    parameter bit LOWEST = 1'b1
) (
    input  logic [N-1:0]  vec,
    input  logic [FW-1:0] floor,
    output logic          found,
    output logic [FW-1:0] idx
);

    logic [N-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand[i] = vec[i] && (ABOVE ? (i > int'(floor)) : (i < int'(floor)));
        end
        // Scan so that the last hit written is the one wanted.
        if (LOWEST) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (cand[i]) begin
                    found = 1'b1;
                    idx   = FW'(i);
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (cand[i]) begin
                    found = 1'b1;
                    idx   = FW'(i);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/request_scheduler.sv
// ============================================================================
// Module      : request_scheduler
// Description : Elevator request scheduler. Latches hall and car requests
//               into sticky pending registers, runs an IDLE/UP/DOWN state
//               machine, clears requests as the car is served and selects
//               the next floor to stop at.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               up, down            - hall request vectors (level)
//               elevator_btn        - in-car floor buttons (level)
//               cur_floor           - floor the car is at or passing
//               arrived             - pulse: car stopped at cur_floor
//               dir                 - 00 IDLE, 01 UP, 10 DOWN
//               target_floor/valid  - next stop and its qualifier
//               pend_up/down/car    - latched pending requests
//               serve               - pulse: a pending bit was cleared
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module request_scheduler #(
    parameter int NFLOORS = elevator_pkg::NFLOORS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NFLOORS-1:0]        up,
    input  logic [NFLOORS-1:0]        down,
    input  logic [NFLOORS-1:0]        elevator_btn,
    input  logic [elevator_pkg::FW-1:0] cur_floor,
    input  logic                      arrived,
    output logic [1:0]                dir,
    output logic [elevator_pkg::FW-1:0] target_floor,
    output logic                      target_valid,
    output logic [NFLOORS-1:0]        pend_up,
    output logic [NFLOORS-1:0]        pend_down,
    output logic [NFLOORS-1:0]        pend_car,
    output logic                      serve
);

    import elevator_pkg::*;

    dir_t               state;
    dir_t               next_state;

    logic [NFLOORS-1:0] gt_mask;
    logic [NFLOORS-1:0] lt_mask;
    logic [NFLOORS-1:0] eq_mask;
    logic [NFLOORS-1:0] any_pend;
    logic               above;
    logic               below;
    logic               here;
    logic               floor_ok;

    logic [NFLOORS-1:0] clr_up;
    logic [NFLOORS-1:0] clr_down;
    logic [NFLOORS-1:0] clr_car;
    logic [NFLOORS-1:0] nxt_up;
    logic [NFLOORS-1:0] nxt_down;
    logic [NFLOORS-1:0] nxt_car;
    logic               nxt_serve;

    logic [FW-1:0]      nxt_target;
    logic               nxt_valid;

    logic               up_pri_found;
    logic [FW-1:0]      up_pri_idx;
    logic               up_sec_found;
    logic [FW-1:0]      up_sec_idx;
    logic               dn_pri_found;
    logic [FW-1:0]      dn_pri_idx;
    logic               dn_sec_found;
    logic [FW-1:0]      dn_sec_idx;

    logic [NFLOORS-1:0] up_or_car;
    logic [NFLOORS-1:0] down_or_car;

    assign dir = state;

    // ------------------------------------------------------------------
    // Position of pending requests relative to the car
    // ------------------------------------------------------------------
    always_comb begin
        gt_mask = '0;
        lt_mask = '0;
        eq_mask = '0;
        for (int i = 0; i < NFLOORS; i++) begin
            gt_mask[i] = (i > int'(cur_floor));
            lt_mask[i] = (i < int'(cur_floor));
            eq_mask[i] = (i == int'(cur_floor));
        end
    end

    assign floor_ok = (int'(cur_floor) < NFLOORS);
    assign any_pend = pend_up | pend_down | pend_car;
    assign above    = |(any_pend & gt_mask);
    assign below    = |(any_pend & lt_mask);
    assign here     = |(any_pend & eq_mask);

    // ------------------------------------------------------------------
    // State machine: next state and clear masks
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        clr_up     = '0;
        clr_down   = '0;
        clr_car    = '0;
        // An out-of-range floor freezes the scheduler entirely.
        if (floor_ok) begin
            case (state)
                DIR_IDLE: begin
                    // Serving the current floor wins over starting a move;
                    // the move is picked up on the following cycle.
                    if (here) begin
                        clr_up   = eq_mask;
                        clr_down = eq_mask;
                        clr_car  = eq_mask;
                    end else if (above) begin
                        next_state = DIR_UP;
                    end else if (below) begin
                        next_state = DIR_DOWN;
                    end
                end
                DIR_UP: begin
                    if (arrived) begin
                        clr_up  = eq_mask;
                        clr_car = eq_mask;
                        // A down-call is only answered here at the top of
                        // the sweep, when the car is about to turn.
                        if (!above) begin
                            clr_down   = eq_mask;
                            next_state = below ? DIR_DOWN : DIR_IDLE;
                        end
                    end
                end
                DIR_DOWN: begin
                    if (arrived) begin
                        clr_down = eq_mask;
                        clr_car  = eq_mask;
                        if (!below) begin
                            clr_up     = eq_mask;
                            next_state = above ? DIR_UP : DIR_IDLE;
                        end
                    end
                end
                default: next_state = DIR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DIR_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Pending registers: a new request in the same cycle beats a clear
    // ------------------------------------------------------------------
    assign nxt_up    = (pend_up   & ~clr_up)   | up;
    assign nxt_down  = (pend_down & ~clr_down) | down;
    assign nxt_car   = (pend_car  & ~clr_car)  | elevator_btn;
    // serve reports bits that actually fall from 1 to 0.
    assign nxt_serve = |((pend_up & ~nxt_up) | (pend_down & ~nxt_down) | (pend_car & ~nxt_car));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_up   <= '0;
            pend_down <= '0;
            pend_car  <= '0;
            serve     <= 1'b0;
        end else begin
            pend_up   <= nxt_up;
            pend_down <= nxt_down;
            pend_car  <= nxt_car;
            serve     <= nxt_serve;
        end
    end

    // ------------------------------------------------------------------
    // Target selection
    // ------------------------------------------------------------------
    assign up_or_car   = pend_up | pend_car;
    assign down_or_car = pend_down | pend_car;

    // Going up: nearest up/car request above, else farthest down-call above.
    floor_search #(.N(NFLOORS), .ABOVE(1'b1), .LOWEST(1'b1)) u_up_pri (
        .vec   (up_or_car),
        .floor (cur_floor),
        .found (up_pri_found),
        .idx   (up_pri_idx)
    );

    floor_search #(.N(NFLOORS), .ABOVE(1'b1), .LOWEST(1'b0)) u_up_sec (
        .vec   (pend_down),
        .floor (cur_floor),
        .found (up_sec_found),
        .idx   (up_sec_idx)
    );

    // Going down: nearest down/car request below, else farthest up-call below.
    floor_search #(.N(NFLOORS), .ABOVE(1'b0), .LOWEST(1'b0)) u_dn_pri (
        .vec   (down_or_car),
        .floor (cur_floor),
        .found (dn_pri_found),
        .idx   (dn_pri_idx)
    );

    floor_search #(.N(NFLOORS), .ABOVE(1'b0), .LOWEST(1'b1)) u_dn_sec (
        .vec   (pend_up),
        .floor (cur_floor),
        .found (dn_sec_found),
        .idx   (dn_sec_idx)
    );

    // The search uses the direction being entered so that a fresh request
    // reaches target_floor two cycles after it is seen on the inputs.
    always_comb begin
        nxt_target = '0;
        nxt_valid  = 1'b0;
        if (floor_ok) begin
            if (next_state == DIR_UP) begin
                if (up_pri_found) begin
                    nxt_target = up_pri_idx;
                    nxt_valid  = 1'b1;
                end else if (up_sec_found) begin
                    nxt_target = up_sec_idx;
                    nxt_valid  = 1'b1;
                end
            end else if (next_state == DIR_DOWN) begin
                if (dn_pri_found) begin
                    nxt_target = dn_pri_idx;
                    nxt_valid  = 1'b1;
                end else if (dn_sec_found) begin
                    nxt_target = dn_sec_idx;
                    nxt_valid  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_floor <= '0;
            target_valid <= 1'b0;
        end else begin
            target_floor <= nxt_target;
            target_valid <= nxt_valid;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_request_scheduler.sv
// ============================================================================
// Module      : tb_request_scheduler
// Description : Self-checking bench for request_scheduler: directed scenarios
//               followed by random traffic against a floor-by-floor model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_request_scheduler;

    localparam int         NF    = 8;
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_UP   = 2'b01;
    localparam logic [1:0] S_DOWN = 2'b10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NF-1:0] up;
    logic [NF-1:0] down;
    logic [NF-1:0] elevator_btn;
    logic [2:0]    cur_floor;
    logic          arrived;
    logic [1:0]    dir;
    logic [2:0]    target_floor;
    logic          target_valid;
    logic [NF-1:0] pend_up;
    logic [NF-1:0] pend_down;
    logic [NF-1:0] pend_car;
    logic          serve;

    request_scheduler #(.NFLOORS(NF)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .up           (up),
        .down         (down),
        .elevator_btn (elevator_btn),
        .cur_floor    (cur_floor),
        .arrived      (arrived),
        .dir          (dir),
        .target_floor (target_floor),
        .target_valid (target_valid),
        .pend_up      (pend_up),
        .pend_down    (pend_down),
        .pend_car     (pend_car),
        .serve        (serve)
    );

    always #5 clk = ~clk;

    // Reference model state (expected register contents)
    logic [NF-1:0] m_up, m_dn, m_car;
    logic [1:0]    m_dir;
    logic [2:0]    m_tf;
    logic          m_tv;
    logic          m_serve;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("dir",          32'(dir),          32'(m_dir));
        chk("target_valid", 32'(target_valid), 32'(m_tv));
        if (m_tv) chk("target_floor", 32'(target_floor), 32'(m_tf));
        chk("pend_up",      32'(pend_up),      32'(m_up));
        chk("pend_down",    32'(pend_down),    32'(m_dn));
        chk("pend_car",     32'(pend_car),     32'(m_car));
        chk("serve",        32'(serve),        32'(m_serve));
    endtask

    task automatic model_clear();
        m_up = '0; m_dn = '0; m_car = '0;
        m_dir = S_IDLE; m_tf = '0; m_tv = 1'b0; m_serve = 1'b0;
    endtask

    // One clock of the scheduler rules, evaluated on the values present
    // before the edge.
    task automatic model_step();
        int            cur;
        bit            ok, above, below, here;
        logic [NF-1:0] nu, nd, nc;
        logic [1:0]    ndir;
        if (!rst_n) begin
            model_clear();
            return;
        end
        cur = int'(cur_floor);
        ok  = (cur < NF);
        above = 0; below = 0; here = 0;
        for (int f = 0; f < NF; f++) begin
            if (m_up[f] || m_dn[f] || m_car[f]) begin
                if (f > cur)  above = 1;
                if (f < cur)  below = 1;
                if (f == cur) here  = 1;
            end
        end
        nu = m_up; nd = m_dn; nc = m_car; ndir = m_dir;
        if (ok) begin
            if (m_dir == S_IDLE) begin
                if (here) begin
                    nu[cur] = 1'b0; nd[cur] = 1'b0; nc[cur] = 1'b0;
                end else if (above) ndir = S_UP;
                else if (below)     ndir = S_DOWN;
            end else if (m_dir == S_UP && arrived) begin
                nu[cur] = 1'b0; nc[cur] = 1'b0;
                if (!above) begin
                    nd[cur] = 1'b0;
                    ndir = below ? S_DOWN : S_IDLE;
                end
            end else if (m_dir == S_DOWN && arrived) begin
                nd[cur] = 1'b0; nc[cur] = 1'b0;
                if (!below) begin
                    nu[cur] = 1'b0;
                    ndir = above ? S_UP : S_IDLE;
                end
            end
        end
        nu = nu | up; nd = nd | down; nc = nc | elevator_btn;
        m_serve = 1'b0;
        for (int f = 0; f < NF; f++) begin
            if ((m_up[f] && !nu[f]) || (m_dn[f] && !nd[f]) || (m_car[f] && !nc[f])) m_serve = 1'b1;
        end
        m_tv = 1'b0; m_tf = '0;
        if (ok && ndir == S_UP) begin
            for (int f = cur + 1; f < NF && !m_tv; f++)
                if (m_up[f] || m_car[f]) begin m_tv = 1'b1; m_tf = 3'(f); end
            for (int f = NF - 1; f > cur && !m_tv; f--)
                if (m_dn[f]) begin m_tv = 1'b1; m_tf = 3'(f); end
        end else if (ok && ndir == S_DOWN) begin
            for (int f = cur - 1; f >= 0 && !m_tv; f--)
                if (m_dn[f] || m_car[f]) begin m_tv = 1'b1; m_tf = 3'(f); end
            for (int f = 0; f < cur && !m_tv; f++)
                if (m_up[f]) begin m_tv = 1'b1; m_tf = 3'(f); end
        end
        m_up = nu; m_dn = nd; m_car = nc; m_dir = ndir;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk_model();
    endtask

    task automatic clear_inputs();
        up = '0; down = '0; elevator_btn = '0; arrived = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        #1;
        model_clear();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        cur_floor = '0;
        clear_inputs();
        model_clear();

        // Reset values
        @(posedge clk); #1;
        chk_model();
        chk("rst_dir",   32'(dir),          32'(S_IDLE));
        chk("rst_valid", 32'(target_valid), 32'd0);
        chk("rst_tf",    32'(target_floor), 32'd0);
        chk("rst_pend",  32'(pend_up | pend_down | pend_car), 32'd0);
        chk("rst_serve", 32'(serve),        32'd0);
        rst_n = 1'b1;

        // Single hall-up request, latency through latch and select
        cur_floor = 3'd2; up = 8'h20;
        step();
        up = '0;
        chk("p1_pend_up", 32'(pend_up), 32'h20);
        chk("p1_dir_idle", 32'(dir), 32'(S_IDLE));
        step();
        chk("p1_dir", 32'(dir), 32'(S_UP));
        chk("p1_tf",  32'(target_floor), 32'd5);
        chk("p1_tv",  32'(target_valid), 32'd1);

        // Up sweep: car 4, up 6, down 7
        do_reset();
        cur_floor = 3'd3; elevator_btn = 8'h10; up = 8'h40; down = 8'h80;
        step();
        clear_inputs();
        step();
        chk("sw_dir", 32'(dir), 32'(S_UP));
        chk("sw_t4",  32'(target_floor), 32'd4);
        cur_floor = 3'd4; arrived = 1'b1;
        step();
        arrived = 1'b0;
        chk("sw_t6",    32'(target_floor), 32'd6);
        chk("sw_car4",  32'(pend_car), 32'h00);
        chk("sw_serve", 32'(serve), 32'd1);
        step();
        cur_floor = 3'd6; arrived = 1'b1;
        step();
        arrived = 1'b0;
        chk("sw_t7", 32'(target_floor), 32'd7);
        cur_floor = 3'd7; arrived = 1'b1;
        step();
        arrived = 1'b0;
        chk("sw_dn7",  32'(pend_down), 32'h00);
        chk("sw_idle", 32'(dir), 32'(S_IDLE));
        chk("sw_tv0",  32'(target_valid), 32'd0);

        // Serve in place while idle
        do_reset();
        cur_floor = 3'd0; elevator_btn = 8'h01;
        step();
        elevator_btn = '0;
        chk("here_latched", 32'(pend_car), 32'h01);
        step();
        chk("here_serve", 32'(serve), 32'd1);
        chk("here_car",   32'(pend_car), 32'h00);
        chk("here_dir",   32'(dir), 32'(S_IDLE));
        step();
        chk("here_serve_once", 32'(serve), 32'd0);

        // Set beats clear on arrival
        do_reset();
        cur_floor = 3'd0; up = 8'h10; elevator_btn = 8'h10;
        step();
        clear_inputs();
        step();
        chk("sw_tf4", 32'(target_floor), 32'd4);
        cur_floor = 3'd4; arrived = 1'b1; up = 8'h10;
        step();
        clear_inputs();
        chk("sc_up4",  32'(pend_up), 32'h10);
        chk("sc_car4", 32'(pend_car), 32'h00);
        step();
        step();

        // Reset in the middle of a down sweep
        do_reset();
        cur_floor = 3'd7; down = 8'h02; elevator_btn = 8'h40;
        step();
        clear_inputs();
        step();
        chk("md_dir", 32'(dir), 32'(S_DOWN));
        chk("md_tf",  32'(target_floor), 32'd6);
        rst_n = 1'b0;
        #1;
        model_clear();
        chk_model();
        chk("md_rst_pend", 32'(pend_up | pend_down | pend_car), 32'd0);
        chk("md_rst_dir",  32'(dir), 32'(S_IDLE));
        step();
        rst_n = 1'b1;
        step();
        chk("md_no_serve", 32'(serve), 32'd0);
        step();
        chk("md_no_serve2", 32'(serve), 32'd0);

        // Floor boundaries
        do_reset();
        cur_floor = 3'd7; elevator_btn = 8'h01;
        step();
        clear_inputs();
        step();
        chk("b_top_dir", 32'(dir), 32'(S_DOWN));
        chk("b_top_tf",  32'(target_floor), 32'd0);
        do_reset();
        cur_floor = 3'd0; up = 8'h80;
        step();
        clear_inputs();
        step();
        chk("b_bot_dir", 32'(dir), 32'(S_UP));
        chk("b_bot_tf",  32'(target_floor), 32'd7);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rst_n        = ($urandom_range(0, 99) != 0);
            up           = ($urandom_range(0, 5) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            down         = ($urandom_range(0, 5) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            elevator_btn = ($urandom_range(0, 5) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            arrived      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) cur_floor = 3'($urandom_range(0, 7));
            if (!rst_n) begin
                #1;
                model_clear();
                chk_model();
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
